obstacle_field: RTL

Parametrised generator for a field of NUM_OBS scrolling obstacles in the Bee-Scape playfield. Each frame it moves every obstacle left by a programmable speed. An obstacle that leaves the screen respawns at the right-hand edge with a pseudo-random Y from an internal LFSR, and a passed-obstacle score counter increments. Outputs drive the sprite renderer and the collision checker directly and replace the fixed-position obstacle blocks.

---
 rtl/obstacle_field.sv | 95 +++++++++
 1 files changed

// File: rtl/obstacle_field.sv
// Scrolling obstacle field: NUM_OBS obstacles move left by speed each enabled frame,
// respawn at X_SPAWN with an LFSR-derived Y, and a saturating counter tallies respawns.
module obstacle_field #(
    parameter int NUM_OBS   = 4,
    parameter int X_INIT    = 320,
    parameter int X_SPACING = 160,
    parameter int X_SPAWN   = 640,
    parameter int Y_MIN     = 60,
    parameter int Y_MAX     = 400,
    parameter int OBS_W     = 50,
    parameter int OBS_H     = 40
) (
    input  logic                   frame_clk,
    input  logic                   Reset,
    input  logic                   enable,
    input  logic [2:0]             speed,
    output logic [10*NUM_OBS-1:0]  ObsX,
    output logic [10*NUM_OBS-1:0]  ObsY,
    output logic [9:0]             ObsWidth,
    output logic [9:0]             ObsHeight,
    output logic                   wrap_pulse,
    output logic [15:0]            score
);

    localparam logic [9:0] Y_RANGE = 10'(Y_MAX - Y_MIN);
    localparam logic [9:0] Y_BASE  = 10'(Y_MIN);
    localparam logic [9:0] Y_RESET = 10'((Y_MIN + Y_MAX) / 2);
    localparam logic [9:0] SPAWN_X = 10'(X_SPAWN);
    localparam logic [9:0] SEED    = 10'h2A5;

    logic [9:0]            lfsr;
    logic [9:0]            lfsr_next;
    logic [9:0]            step;
    logic [NUM_OBS-1:0]    respawn;
    logic [10*NUM_OBS-1:0] x_next;
    logic [10*NUM_OBS-1:0] y_next;
    logic [10*NUM_OBS-1:0] x_reset;
    logic [3:0]            respawn_cnt;
    logic [16:0]           score_sum;
    logic [15:0]           score_next;

    function automatic logic [9:0] rotl10(input logic [9:0] v, input int n);
        rotl10 = (v << n) | (v >> (10 - n));
    endfunction

    // The band holds at least 256 values, so one conditional subtraction folds
    // any 9-bit offset back into range.
    function automatic logic [9:0] map_y(input logic [9:0] v);
        logic [9:0] off;
        off = {1'b0, v[8:0]};
        if (off > Y_RANGE)
            off = off - Y_RANGE - 10'd1;
        map_y = Y_BASE + off;
    endfunction

    assign ObsWidth  = 10'(OBS_W);
    assign ObsHeight = 10'(OBS_H);

    assign step      = {7'b0, speed};
    assign lfsr_next = {lfsr[8:0], lfsr[9] ^ lfsr[6]};

    for (genvar i = 0; i < NUM_OBS; i++) begin : g_obs
        logic [9:0] x_cur;
        assign x_cur                = ObsX[10*i +: 10];
        assign respawn[i]           = x_cur < step;
        assign x_next[10*i +: 10]   = respawn[i] ? SPAWN_X : x_cur - step;
        assign y_next[10*i +: 10]   = respawn[i] ? map_y(rotl10(lfsr, i)) : ObsY[10*i +: 10];
        assign x_reset[10*i +: 10]  = 10'(X_INIT + i * X_SPACING);
    end

    always_comb begin
        respawn_cnt = 4'($countones(respawn));
        score_sum   = {1'b0, score} + {13'b0, respawn_cnt};
        score_next  = score_sum[16] ? '1 : score_sum[15:0];
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            ObsX       <= x_reset;
            ObsY       <= {NUM_OBS{Y_RESET}};
            lfsr       <= SEED;
            score      <= '0;
            wrap_pulse <= 1'b0;
        end else if (enable) begin
            ObsX       <= x_next;
            ObsY       <= y_next;
            lfsr       <= lfsr_next;
            score      <= score_next;
            wrap_pulse <= |respawn;
        end else begin
            wrap_pulse <= 1'b0;
        end
    end

endmodule
